flag_int_ctrl: RTL

- Flag-side partner of the MCU interrupt path. Holds the C, Z and I flags and their shadow copies.
- Detects and latches external interrupt requests. Decides when an interrupt is taken, then saves C/Z to the shadows and masks I.
- On RETIE/RETID it restores C/Z from the shadows.
- Sits between the control unit (flag strobes, fetch boundary, return strobes) and the ALU/branch logic, which consumes the flag outputs.

---
 rtl/mcu_pkg.sv | 10 +
 rtl/flag_reg.sv | 40 ++++
 rtl/flag_int_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared MCU types for the interrupt/flag path.
package mcu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TAKE,
      ISR
   } int_state_t;

endpackage

// File: rtl/flag_reg.sv
// One-bit status flag with fixed write priority: restore > clr > set > ld > hold.
module flag_reg (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restore,
   input  logic i_restore_val,
   input  logic i_clr,
   input  logic i_set,
   input  logic i_ld,
   input  logic i_d,
   output logic o_q
);

   logic r_q;
   logic w_q_nxt;

   always_comb begin
      w_q_nxt = r_q;
      if (i_restore) begin
         w_q_nxt = i_restore_val;
      end else if (i_clr) begin
         w_q_nxt = 1'b0;
      end else if (i_set) begin
         w_q_nxt = 1'b1;
      end else if (i_ld) begin
         w_q_nxt = i_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= 1'b0;
      end else begin
         r_q <= w_q_nxt;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/flag_int_ctrl.sv
// C/Z/I flags with shadow save on interrupt entry and restore on RETIE/RETID.
module flag_int_ctrl
   import mcu_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic c_in,
   input  logic z_in,
   input  logic flg_c_ld,
   input  logic flg_c_set,
   input  logic flg_c_clr,
   input  logic flg_z_ld,
   input  logic i_set,
   input  logic i_clr,
   input  logic boundary,
   input  logic int_req,
   input  logic retie,
   input  logic retid,
   output logic c_flag,
   output logic z_flag,
   output logic i_flag,
   output logic int_take,
   output logic in_isr
);

   int_state_t r_state;
   int_state_t w_state_nxt;

   logic r_i_flag;
   logic r_shadow_c;
   logic r_shadow_z;
   logic r_pending;
   logic r_req_prev;

   logic w_c;
   logic w_z;
   logic w_rise;
   logic w_take;
   logic w_restore;

   assign w_rise    = int_req & ~r_req_prev;
   assign w_take    = (r_state == IDLE) & r_pending & r_i_flag & boundary;
   assign w_restore = (r_state == ISR) & (retie | retid);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_take) w_state_nxt = TAKE;
         TAKE:    w_state_nxt = ISR;
         ISR:     if (retie | retid) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A fresh rise in the take cycle must survive the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_req_prev <= 1'b0;
         r_pending  <= 1'b0;
         r_shadow_c <= 1'b0;
         r_shadow_z <= 1'b0;
         r_i_flag   <= 1'b0;
      end else begin
         r_req_prev <= int_req;
         if (w_rise) begin
            r_pending <= 1'b1;
         end else if (w_take) begin
            r_pending <= 1'b0;
         end
         if (w_take) begin
            r_shadow_c <= w_c;
            r_shadow_z <= w_z;
         end
         if (w_take) begin
            r_i_flag <= 1'b0;
         end else if (w_restore) begin
            r_i_flag <= retie;
         end else if (i_clr) begin
            r_i_flag <= 1'b0;
         end else if (i_set) begin
            r_i_flag <= 1'b1;
         end
      end
   end

   flag_reg u_c_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_restore     (w_restore),
      .i_restore_val (r_shadow_c),
      .i_clr         (flg_c_clr),
      .i_set         (flg_c_set),
      .i_ld          (flg_c_ld),
      .i_d           (c_in),
      .o_q           (w_c)
   );

   flag_reg u_z_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_restore     (w_restore),
      .i_restore_val (r_shadow_z),
      .i_clr         (1'b0),
      .i_set         (1'b0),
      .i_ld          (flg_z_ld),
      .i_d           (z_in),
      .o_q           (w_z)
   );

   assign c_flag   = w_c;
   assign z_flag   = w_z;
   assign i_flag   = r_i_flag;
   assign int_take = (r_state == TAKE);
   assign in_isr   = (r_state != IDLE);

endmodule
